// File: rtl/arithmetic_sequencer.sv
// Control stage in front of the 8-bit ArithmeticUnit: fetches operands A/B from the
// register file, drives the ALU for one cycle, records result and flags, writes back.
module arithmetic_sequencer #(
    parameter int ADDR_WIDTH = 3,
    parameter int SRC_A      = 0,
    parameter int SRC_B      = 1,
    parameter int DEST       = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instrValid,
    input  logic [7:0]            instruction,
    output logic                  instrReady,
    output logic [ADDR_WIDTH-1:0] regReadAddr,
    output logic                  regReadEn,
    input  logic [7:0]            regReadData,
    output logic                  regWriteEn,
    output logic [ADDR_WIDTH-1:0] regWriteAddr,
    output logic [7:0]            regWriteData,
    output logic [2:0]            aluOpcode,
    output logic [7:0]            aluOperandA,
    output logic [7:0]            aluOperandB,
    input  logic [7:0]            aluResult,
    output logic [3:0]            flags,
    output logic                  done,
    output logic                  illegal
);

    localparam logic [ADDR_WIDTH-1:0] LP_SRC_A = ADDR_WIDTH'(SRC_A);
    localparam logic [ADDR_WIDTH-1:0] LP_SRC_B = ADDR_WIDTH'(SRC_B);
    localparam logic [ADDR_WIDTH-1:0] LP_DEST  = ADDR_WIDTH'(DEST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_WAIT_B,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    // Flags packed as {zero, negative, carry, overflow}; carry means borrow for SUB.
    function automatic logic [3:0] f_flags(input logic       is_sub,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] res);
        logic [8:0] sum;
        logic       carry;
        logic       ovf;
        sum   = {1'b0, a} + {1'b0, b};
        carry = is_sub ? (a < b) : sum[8];
        ovf   = is_sub ? ((a[7] != b[7]) && (res[7] != a[7]))
                       : ((a[7] == b[7]) && (res[7] != a[7]));
        return {(res == 8'h00), res[7], carry, ovf};
    endfunction

    state_t                r_state;
    logic [2:0]            r_op;
    logic [7:0]            r_opA;
    logic [7:0]            r_opB;
    logic [7:0]            r_result;
    logic [3:0]            r_flags;
    logic                  r_ready;
    logic                  r_readEn;
    logic [ADDR_WIDTH-1:0] r_readAddr;
    logic                  r_writeEn;
    logic                  r_done;
    logic                  r_illegal;
    logic [2:0]            r_aluOp;
    logic [7:0]            r_aluA;
    logic [7:0]            r_aluB;

    logic                  w_legal;
    logic [3:0]            w_flags;

    assign w_legal = (instruction[7:3] == 5'b01000) && (instruction[2:1] == 2'b10);
    assign w_flags = f_flags(r_op[0], r_opA, r_opB, aluResult);

    // Outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= 3'b000;
            r_opA      <= 8'h00;
            r_opB      <= 8'h00;
            r_result   <= 8'h00;
            r_flags    <= 4'h0;
            r_ready    <= 1'b1;
            r_readEn   <= 1'b0;
            r_readAddr <= '0;
            r_writeEn  <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_aluOp    <= 3'b000;
            r_aluA     <= 8'h00;
            r_aluB     <= 8'h00;
        end else begin
            r_readEn   <= 1'b0;
            r_readAddr <= '0;
            r_writeEn  <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instrValid) begin
                        if (w_legal) begin
                            r_op       <= instruction[2:0];
                            r_state    <= S_READ_A;
                            r_ready    <= 1'b0;
                            r_readEn   <= 1'b1;
                            r_readAddr <= LP_SRC_A;
                        end else begin
                            r_illegal  <= 1'b1;
                        end
                    end
                end
                S_READ_A: begin
                    r_state    <= S_READ_B;
                    r_readEn   <= 1'b1;
                    r_readAddr <= LP_SRC_B;
                end
                S_READ_B: begin
                    r_opA   <= regReadData;
                    r_state <= S_WAIT_B;
                end
                S_WAIT_B: begin
                    r_opB   <= regReadData;
                    r_aluOp <= r_op;
                    r_aluA  <= r_opA;
                    r_aluB  <= regReadData;
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_result  <= aluResult;
                    r_flags   <= w_flags;
                    r_aluOp   <= 3'b000;
                    r_aluA    <= 8'h00;
                    r_aluB    <= 8'h00;
                    r_writeEn <= 1'b1;
                    r_done    <= 1'b1;
                    r_state   <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instrReady   = r_ready;
    assign regReadEn    = r_readEn;
    assign regReadAddr  = r_readAddr;
    assign regWriteEn   = r_writeEn;
    assign regWriteAddr = LP_DEST;
    assign regWriteData = r_result;
    assign aluOpcode    = r_aluOp;
    assign aluOperandA  = r_aluA;
    assign aluOperandB  = r_aluB;
    assign flags        = r_flags;
    assign done         = r_done;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_arithmetic_sequencer.sv
// Bench for arithmetic_sequencer: register file and ALU models, write-back scoreboard.
module tb_arithmetic_sequencer;

    logic       clock;
    logic       reset;
    logic       instrValid;
    logic [7:0] instruction;
    logic       instrReady;
    logic [2:0] regReadAddr;
    logic       regReadEn;
    logic [7:0] regReadData;
    logic       regWriteEn;
    logic [2:0] regWriteAddr;
    logic [7:0] regWriteData;
    logic [2:0] aluOpcode;
    logic [7:0] aluOperandA;
    logic [7:0] aluOperandB;
    logic [7:0] aluResult;
    logic [3:0] flags;
    logic       done;
    logic       illegal;

    arithmetic_sequencer #(.ADDR_WIDTH(3), .SRC_A(0), .SRC_B(1), .DEST(0)) dut (
        .clock       (clock),
        .reset       (reset),
        .instrValid  (instrValid),
        .instruction (instruction),
        .instrReady  (instrReady),
        .regReadAddr (regReadAddr),
        .regReadEn   (regReadEn),
        .regReadData (regReadData),
        .regWriteEn  (regWriteEn),
        .regWriteAddr(regWriteAddr),
        .regWriteData(regWriteData),
        .aluOpcode   (aluOpcode),
        .aluOperandA (aluOperandA),
        .aluOperandB (aluOperandB),
        .aluResult   (aluResult),
        .flags       (flags),
        .done        (done),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file with one synchronous read port and a bench-side preload path.
    logic [7:0] regs [8];
    logic       ld_en;
    logic [7:0] ld_a;
    logic [7:0] ld_b;

    always @(posedge clock) begin
        if (regReadEn) regReadData <= regs[regReadAddr];
        if (ld_en) begin
            regs[0] <= ld_a;
            regs[1] <= ld_b;
        end else if (regWriteEn) begin
            regs[regWriteAddr] <= regWriteData;
        end
    end

    assign aluResult = (aluOpcode == 3'b100) ? aluOperandA + aluOperandB :
                       (aluOpcode == 3'b101) ? aluOperandA - aluOperandB : 8'h00;

    typedef struct {
        logic [7:0] d;
        logic [3:0] f;
    } exp_t;
    exp_t sb[$];

    int         n_vec;
    int         n_err;
    logic [3:0] last_flags;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [3:0] f);
        logic [8:0] s;
        logic       c;
        logic       v;
        if (sub) begin
            r = a - b;
            c = (a < b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end
        f = {(r == 8'h00), r[7], c, v};
    endfunction

    // Every write-back is matched against the oldest outstanding expectation.
    always @(negedge clock) begin
        if (regWriteEn) begin
            if (sb.size() == 0) begin
                chk_eq("unexpected_write", 32'(regWriteData), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("wr_data", 32'(regWriteData), 32'(e.d));
                chk_eq("wr_addr", 32'(regWriteAddr), 32'd0);
                chk_eq("wr_flags", 32'(flags), 32'(e.f));
            end
        end
    end

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        ld_a  = a;
        ld_b  = b;
        ld_en = 1'b1;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // rst_at: 0 = no reset, 4 = reset during EXECUTE, 5 = reset during WRITEBACK.
    task automatic do_instr(input logic [7:0] ib, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_r, input logic [3:0] exp_f, input int rst_at);
        exp_t e;
        load(a, b);
        e.d = exp_r;
        e.f = exp_f;
        if (rst_at != 4) sb.push_back(e);
        @(negedge clock);
        chk_eq("ready_before", 32'(instrReady), 32'd1);
        instrValid  = 1'b1;
        instruction = ib;
        @(negedge clock);
        instrValid  = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clock);
            if (rst_at != 0 && k == rst_at + 1) begin
                reset = 1'b0;
                chk_eq("rst_ready", 32'(instrReady), 32'd1);
                chk_eq("rst_wen", 32'(regWriteEn), 32'd0);
                chk_eq("rst_done", 32'(done), 32'd0);
                chk_eq("rst_flags", 32'(flags), 32'd0);
                last_flags = 4'h0;
                break;
            end
            if (k <= 5) begin
                chk_eq("busy_ready", 32'(instrReady), 32'd0);
                chk_eq("rd_en", 32'(regReadEn), (k <= 2) ? 32'd1 : 32'd0);
                chk_eq("rd_addr", 32'(regReadAddr), (k == 2) ? 32'd1 : 32'd0);
                chk_eq("alu_op", 32'(aluOpcode), (k == 4) ? 32'(ib[2:0]) : 32'd0);
                chk_eq("wr_en", 32'(regWriteEn), (k == 5) ? 32'd1 : 32'd0);
                chk_eq("done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
                chk_eq("flags_seq", 32'(flags), (k == 5) ? 32'(exp_f) : 32'(last_flags));
            end else begin
                chk_eq("ready_after", 32'(instrReady), 32'd1);
                chk_eq("wr_en_after", 32'(regWriteEn), 32'd0);
                chk_eq("flags_hold", 32'(flags), 32'(exp_f));
                last_flags = exp_f;
            end
            if (k == rst_at) reset = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] ill [3];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rr;
        logic [3:0] rf;
        logic       rs;
        exp_t       e;
        n_vec       = 0;
        n_err       = 0;
        last_flags  = 4'h0;
        reset       = 1'b1;
        instrValid  = 1'b0;
        instruction = 8'h00;
        ld_en       = 1'b0;
        ld_a        = 8'h00;
        ld_b        = 8'h00;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        repeat (2) @(negedge clock);
        chk_eq("reset_ready", 32'(instrReady), 32'd1);
        chk_eq("reset_rd_en", 32'(regReadEn), 32'd0);
        chk_eq("reset_wr_en", 32'(regWriteEn), 32'd0);
        chk_eq("reset_done", 32'(done), 32'd0);
        chk_eq("reset_illegal", 32'(illegal), 32'd0);
        chk_eq("reset_alu_op", 32'(aluOpcode), 32'd0);
        chk_eq("reset_flags", 32'(flags), 32'd0);
        chk_eq("reset_wdata", 32'(regWriteData), 32'd0);
        reset = 1'b0;

        do_instr(8'h44, 8'h7F, 8'h01, 8'h80, 4'b0101, 0);
        do_instr(8'h45, 8'h00, 8'h01, 8'hFF, 4'b0110, 0);
        do_instr(8'h45, 8'h05, 8'h05, 8'h00, 4'b1000, 0);
        do_instr(8'h45, 8'h80, 8'h01, 8'h7F, 4'b0001, 0);
        do_instr(8'h44, 8'hFF, 8'h01, 8'h00, 4'b1010, 0);
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            model(rs, ra, rb, rr, rf);
            do_instr({7'b0100010, rs}, ra, rb, rr, rf, 0);
        end

        // Illegal bytes back to back, then idle again.
        ill[0] = 8'h00;
        ill[1] = 8'h46;
        ill[2] = 8'hC4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i > 0) chk_eq("illegal_pulse", 32'(illegal), 32'd1);
            chk_eq("ill_ready", 32'(instrReady), 32'd1);
            chk_eq("ill_rd_en", 32'(regReadEn), 32'd0);
            chk_eq("ill_wr_en", 32'(regWriteEn), 32'd0);
            instrValid  = 1'b1;
            instruction = ill[i];
        end
        @(negedge clock);
        chk_eq("illegal_pulse", 32'(illegal), 32'd1);
        instrValid = 1'b0;
        @(negedge clock);
        chk_eq("illegal_clear", 32'(illegal), 32'd0);
        chk_eq("ill_rd_en", 32'(regReadEn), 32'd0);
        chk_eq("ill_flags", 32'(flags), 32'(last_flags));
        chk_eq("ill_ready", 32'(instrReady), 32'd1);

        // instrValid held high across two ADDs: accepts 6 cycles apart.
        load(8'h7F, 8'h01);
        e.d = 8'h80; e.f = 4'b0101; sb.push_back(e);
        e.d = 8'h81; e.f = 4'b0100; sb.push_back(e);
        @(negedge clock);
        instrValid  = 1'b1;
        instruction = 8'h44;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            chk_eq("held_ready", 32'(instrReady), (k == 6 || k == 12) ? 32'd1 : 32'd0);
            chk_eq("held_wr_en", 32'(regWriteEn), (k == 5 || k == 11) ? 32'd1 : 32'd0);
            if (k == 11) instrValid = 1'b0;
        end
        @(negedge clock);
        chk_eq("held_no_third", 32'(instrReady), 32'd1);
        chk_eq("held_rd_en", 32'(regReadEn), 32'd0);
        last_flags = 4'b0100;

        // Reset in EXECUTE aborts; reset in WRITEBACK keeps the write.
        do_instr(8'h44, 8'h10, 8'h20, 8'h30, 4'b0000, 4);
        do_instr(8'h45, 8'h10, 8'h20, 8'hF0, 4'b0110, 5);

        // Reset coincident with instrValid: no accept.
        @(negedge clock);
        reset       = 1'b1;
        instrValid  = 1'b1;
        instruction = 8'h44;
        @(negedge clock);
        reset      = 1'b0;
        instrValid = 1'b0;
        chk_eq("rstv_ready", 32'(instrReady), 32'd1);
        chk_eq("rstv_rd_en", 32'(regReadEn), 32'd0);
        @(negedge clock);
        chk_eq("rstv_ready2", 32'(instrReady), 32'd1);
        chk_eq("rstv_rd_en2", 32'(regReadEn), 32'd0);
        chk_eq("rstv_flags", 32'(flags), 32'd0);

        repeat (3) @(negedge clock);
        chk_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
